// File: rtl/fifo_rd_stream_if.sv
// fifo_rd_stream_if: FIFO read port plus valid/ready stream seen by the FIFO read-side master.
interface fifo_rd_stream_if #(
    parameter int FIFO_WIDTH = 16
);
    logic                  fifo_empty;
    logic                  fifo_underflow;
    logic [FIFO_WIDTH-1:0] fifo_data_out;
    logic                  fifo_rd_en;
    logic                  m_valid;
    logic                  m_ready;
    logic [FIFO_WIDTH-1:0] m_data;

    modport master (
        input  fifo_empty, fifo_underflow, fifo_data_out, m_ready,
        output fifo_rd_en, m_valid, m_data
    );

    modport slave (
        output fifo_empty, fifo_underflow, fifo_data_out, m_ready,
        input  fifo_rd_en, m_valid, m_data
    );
endinterface

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains a synchronous FIFO into a valid/ready stream through a 2-entry skid buffer.
module fifo_rd_stream #(
    parameter int FIFO_WIDTH = 16,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    fifo_rd_stream_if.master bus,
    output logic             err_underflow,
    output logic [CNT_W-1:0] xfer_count
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

    state_t                state;
    logic                  inflight;
    logic                  pop;
    logic [1:0]            occ;
    logic [FIFO_WIDTH-1:0] head;
    logic [FIFO_WIDTH-1:0] tail;

    assign occ         = state;
    assign pop         = bus.m_valid && bus.m_ready;
    assign bus.m_valid = state != EMPTY;
    assign bus.m_data  = head;
    // Credit rule: buffered + arriving - leaving must leave room for the word this read returns.
    assign bus.fifo_rd_en = rst_n && enable && !bus.fifo_empty &&
                            ({1'b0, occ} + {2'b0, inflight} <= 3'd1 + {2'b0, pop});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= EMPTY;
            inflight      <= 1'b0;
            head          <= '0;
            tail          <= '0;
            err_underflow <= 1'b0;
            xfer_count    <= '0;
        end else begin
            inflight <= bus.fifo_rd_en;
            if (bus.fifo_underflow) err_underflow <= 1'b1;
            if (pop) xfer_count <= xfer_count + 1'b1;
            unique case (state)
                EMPTY: if (inflight) begin
                    head  <= bus.fifo_data_out;
                    state <= ONE;
                end
                ONE: begin
                    if (inflight && pop) head <= bus.fifo_data_out;
                    else if (inflight) begin
                        tail  <= bus.fifo_data_out;
                        state <= TWO;
                    end else if (pop) state <= EMPTY;
                end
                TWO: if (pop) begin
                    head  <= tail;
                    state <= ONE;
                end
                default: state <= EMPTY;
            endcase
        end
    end

    assert property (@(posedge clk) disable iff (!rst_n) !(state == TWO && inflight));
endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: directed tests of the FIFO read-side stream master against a behavioural FIFO.
module tb_fifo_rd_stream;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b1;
    logic       uf_force = 1'b0;
    logic       model_uf = 1'b0;
    logic       err_underflow;
    logic [3:0] xfer_count;

    logic [15:0] mem [0:255];
    logic [7:0]  wp = 8'd0;
    logic [7:0]  rp = 8'd0;
    logic [15:0] got [0:255];
    int gn = 0, rdcnt = 0, ufcnt = 0;
    int checks = 0, errors = 0;

    fifo_rd_stream_if #(.FIFO_WIDTH(16)) bus ();

    fifo_rd_stream #(.FIFO_WIDTH(16), .CNT_W(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .bus(bus),
        .err_underflow(err_underflow),
        .xfer_count(xfer_count)
    );

    always #5 clk = ~clk;

    assign bus.fifo_empty     = (wp == rp);
    assign bus.fifo_underflow = uf_force | model_uf;

    // Behavioural FIFO read port (1-cycle registered data) plus delivered-word monitor.
    always @(posedge clk) begin
        model_uf <= 1'b0;
        if (bus.fifo_rd_en) begin
            rdcnt <= rdcnt + 1;
            if (wp != rp) begin
                bus.fifo_data_out <= mem[rp];
                rp <= rp + 8'd1;
            end else begin
                model_uf <= 1'b1;
                ufcnt <= ufcnt + 1;
            end
        end
        if (bus.m_valid && bus.m_ready) begin
            got[gn] <= bus.m_data;
            gn <= gn + 1;
        end
    end

    task automatic load(input logic [15:0] w);
        mem[wp] = w;
        wp = wp + 8'd1;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        enable = 1'b1;
        bus.m_ready = 1'b0;
        load(16'h5A5A);
        tick(2);
        #1;
        checks++; if (bus.fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b want 0", bus.fifo_rd_en); end
        checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b want 0", bus.m_valid); end
        checks++; if (bus.m_data !== 16'h0) begin errors++; $display("FAIL reset_m_data: got %h want 0000", bus.m_data); end
        checks++; if (xfer_count !== 4'd0) begin errors++; $display("FAIL reset_xfer_count: got %0d want 0", xfer_count); end
        checks++; if (err_underflow !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err_underflow); end
        rst_n = 1'b1;
        bus.m_ready = 1'b1;
        tick(6);
        checks++; if (gn !== 1 || got[0] !== 16'h5A5A) begin errors++; $display("FAIL reset_first_word: got n=%0d w=%h want n=1 w=5a5a", gn, got[0]); end
        checks++; if (xfer_count !== 4'd1) begin errors++; $display("FAIL reset_first_count: got %0d want 1", xfer_count); end
    endtask

    task automatic test_stream;
        int g0;
        logic [5:0] rdv, vv;
        logic [15:0] d [0:5];
        g0 = gn;
        load(16'hA001); load(16'hA002); load(16'hA003);
        #1;
        for (int k = 0; k < 6; k++) begin
            rdv[k] = bus.fifo_rd_en;
            vv[k] = bus.m_valid;
            d[k] = bus.m_data;
            tick(1);
            #1;
        end
        checks++; if (rdv !== 6'b000111) begin errors++; $display("FAIL stream_rd_en_pattern: got %b want 000111", rdv); end
        checks++; if (vv !== 6'b011100) begin errors++; $display("FAIL stream_valid_pattern: got %b want 011100", vv); end
        for (int k = 0; k < 3; k++) begin
            checks++; if (d[k+2] !== 16'hA001 + 16'(k)) begin errors++; $display("FAIL stream_word%0d: got %h want %h", k, d[k+2], 16'hA001 + 16'(k)); end
        end
        checks++; if (gn - g0 !== 3) begin errors++; $display("FAIL stream_count: got %0d want 3", gn - g0); end
        checks++; if (xfer_count !== 4'd4) begin errors++; $display("FAIL stream_xfer_count: got %0d want 4", xfer_count); end
    endtask

    task automatic test_backpressure;
        int r0;
        r0 = rdcnt;
        bus.m_ready = 1'b0;
        for (int k = 0; k < 8; k++) load(16'hB000 + 16'(k));
        tick(6);
        #1;
        checks++; if (rdcnt - r0 !== 2) begin errors++; $display("FAIL bp_reads: got %0d want 2", rdcnt - r0); end
        checks++; if (bus.fifo_rd_en !== 1'b0) begin errors++; $display("FAIL bp_rd_en_held: got %b want 0", bus.fifo_rd_en); end
        checks++; if (bus.m_valid !== 1'b1 || bus.m_data !== 16'hB000) begin errors++; $display("FAIL bp_head_held: got v=%b d=%h want v=1 d=b000", bus.m_valid, bus.m_data); end
        bus.m_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            checks++; if (bus.m_valid !== 1'b1 || bus.m_data !== 16'hB000 + 16'(k)) begin errors++; $display("FAIL bp_word%0d: got v=%b d=%h want v=1 d=%h", k, bus.m_valid, bus.m_data, 16'hB000 + 16'(k)); end
            tick(1);
            #1;
        end
        checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL bp_drained: got %b want 0", bus.m_valid); end
        checks++; if (err_underflow !== 1'b0 || ufcnt !== 0) begin errors++; $display("FAIL bp_no_underflow: got err=%b reads_on_empty=%0d want 0 0", err_underflow, ufcnt); end
        checks++; if (xfer_count !== 4'd12) begin errors++; $display("FAIL bp_xfer_count: got %0d want 12", xfer_count); end
    endtask

    task automatic test_empty_enable;
        int r0, g0;
        logic seen;
        r0 = rdcnt;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick(1);
            #1;
            seen = seen | bus.fifo_rd_en;
        end
        checks++; if (seen !== 1'b0 || rdcnt - r0 !== 0) begin errors++; $display("FAIL empty_no_read: got seen=%b reads=%0d want 0 0", seen, rdcnt - r0); end
        enable = 1'b0;
        for (int k = 0; k < 4; k++) load(16'hC000 + 16'(k));
        tick(10);
        checks++; if (rdcnt - r0 !== 0 || bus.m_valid !== 1'b0) begin errors++; $display("FAIL disabled_no_read: got reads=%0d v=%b want 0 0", rdcnt - r0, bus.m_valid); end
        enable = 1'b1;
        g0 = gn;
        tick(10);
        checks++; if (gn - g0 !== 4) begin errors++; $display("FAIL enable_count: got %0d want 4", gn - g0); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (got[g0+k] !== 16'hC000 + 16'(k)) begin errors++; $display("FAIL enable_word%0d: got %h want %h", k, got[g0+k], 16'hC000 + 16'(k)); end
        end
        checks++; if (xfer_count !== 4'd0) begin errors++; $display("FAIL enable_count_wrap: got %0d want 0", xfer_count); end
    endtask

    task automatic test_midop_reset;
        int g0;
        bus.m_ready = 1'b0;
        for (int k = 0; k < 4; k++) load(16'hD000 + 16'(k));
        tick(6);
        #1;
        checks++; if (bus.m_valid !== 1'b1 || bus.m_data !== 16'hD000) begin errors++; $display("FAIL midrst_full: got v=%b d=%h want v=1 d=d000", bus.m_valid, bus.m_data); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.m_valid !== 1'b0 || xfer_count !== 4'd0 || bus.fifo_rd_en !== 1'b0) begin errors++; $display("FAIL midrst_clear: got v=%b cnt=%0d rd=%b want 0 0 0", bus.m_valid, xfer_count, bus.fifo_rd_en); end
        tick(1);
        rst_n = 1'b1;
        bus.m_ready = 1'b1;
        g0 = gn;
        tick(8);
        checks++; if (gn - g0 !== 2) begin errors++; $display("FAIL midrst_count: got %0d want 2", gn - g0); end
        checks++; if (got[g0] !== 16'hD002 || got[g0+1] !== 16'hD003) begin errors++; $display("FAIL midrst_order: got %h %h want d002 d003", got[g0], got[g0+1]); end
        checks++; if (xfer_count !== 4'd2) begin errors++; $display("FAIL midrst_xfer_count: got %0d want 2", xfer_count); end
    endtask

    task automatic test_wrap_error;
        int g0;
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        g0 = gn;
        for (int k = 0; k < 17; k++) load(16'hE000 + 16'(k));
        tick(25);
        checks++; if (gn - g0 !== 17 || got[g0+16] !== 16'hE010) begin errors++; $display("FAIL wrap_words: got n=%0d last=%h want 17 e010", gn - g0, got[g0+16]); end
        checks++; if (xfer_count !== 4'd1) begin errors++; $display("FAIL wrap_count: got %0d want 1", xfer_count); end
        checks++; if (err_underflow !== 1'b0) begin errors++; $display("FAIL err_before: got %b want 0", err_underflow); end
        uf_force = 1'b1;
        tick(1);
        uf_force = 1'b0;
        #1;
        checks++; if (err_underflow !== 1'b1) begin errors++; $display("FAIL err_set: got %b want 1", err_underflow); end
        tick(5);
        checks++; if (err_underflow !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", err_underflow); end
        rst_n = 1'b0;
        #1;
        checks++; if (err_underflow !== 1'b0) begin errors++; $display("FAIL err_reset: got %b want 0", err_underflow); end
        tick(1);
        rst_n = 1'b1;
    endtask

    initial begin
        bus.m_ready = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_empty_enable();
        test_midop_reset();
        test_wrap_error();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
